// File: rtl/wavefront_if.sv
// Handshake and status bundle between the pixel source and the wavefront sequencer.
// Geometry parameters size the position and window-tag fields.
interface wavefront_if #(
  parameter int unsigned IMG_W = 32,
  parameter int unsigned IMG_H = 32
);
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  logic             start;
  logic             pix_valid;
  logic             pix_ready;
  logic             shift_en;
  logic [COL_W-1:0] col_idx;
  logic [ROW_W-1:0] row_idx;
  logic             win_valid;
  logic [COL_W-1:0] win_col;
  logic [ROW_W-1:0] win_row;
  logic             busy;
  logic             done;

  modport master (
    output start, pix_valid,
    input  pix_ready, shift_en, col_idx, row_idx, win_valid, win_col, win_row, busy, done
  );

  modport slave (
    input  start, pix_valid,
    output pix_ready, shift_en, col_idx, row_idx, win_valid, win_col, win_row, busy, done
  );
endinterface

// File: rtl/wavefront_sched.sv
// Frame sequencer for the skewed line-buffer stage: counts raster position, issues shift
// enables and emits window strobes delay-matched to the free-running skew pipeline.
module wavefront_sched #(
  parameter int unsigned IMG_W           = 32,
  parameter int unsigned IMG_H           = 32,
  parameter int unsigned KERNEL          = 5,
  parameter int unsigned WAVEFRONT_DELAY = 4
) (
  input logic         clk,
  input logic         rst,
  wavefront_if.slave  bus
);
  localparam int unsigned LAT   = (KERNEL - 1) * WAVEFRONT_DELAY;
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned CNT_W = $clog2(LAT + 1);

  typedef enum logic [2:0] {StIdle, StFill, StRun, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [CNT_W-1:0] drain_q;
  logic             ready, is_busy, is_done;
  logic             beat, col_last, frame_last, cand;

  logic [LAT-1:0]   vld_q;
  logic [COL_W-1:0] tcol_q [LAT];
  logic [ROW_W-1:0] trow_q [LAT];

  assign beat       = bus.pix_valid & ready;
  assign col_last   = (col_q == COL_W'(IMG_W - 1));
  assign frame_last = col_last && (row_q == ROW_W'(IMG_H - 1));
  // RUN covers every beat whose row can close a window, including the final beat.
  assign cand       = beat && (state_q == StRun) &&
                      (row_q >= ROW_W'(KERNEL - 1)) && (col_q >= COL_W'(KERNEL - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.start) state_d = StFill;
      StFill:  if (beat && col_last && (row_q == ROW_W'(KERNEL - 2))) state_d = StRun;
      StRun:   if (beat && frame_last) state_d = StDrain;
      StDrain: if (drain_q == CNT_W'(LAT - 1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready   = 1'b0;
    is_busy = 1'b0;
    is_done = 1'b0;
    case (state_q)
      StFill, StRun: begin
        ready   = 1'b1;
        is_busy = 1'b1;
      end
      StDrain: is_busy = 1'b1;
      StDone:  is_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      drain_q <= '0;
    end else begin
      if (state_q == StIdle && bus.start) begin
        col_q <= '0;
        row_q <= '0;
      end else if (beat) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= frame_last ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
      drain_q <= (state_q == StDrain) ? drain_q + CNT_W'(1) : '0;
    end
  end

  // Advances every clock regardless of stalls so strobes stay aligned with the skew stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        tcol_q[i] <= '0;
        trow_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= cand;
      tcol_q[0] <= col_q - COL_W'(KERNEL - 1);
      trow_q[0] <= row_q - ROW_W'(KERNEL - 1);
      for (int unsigned i = 1; i < LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        tcol_q[i] <= tcol_q[i-1];
        trow_q[i] <= trow_q[i-1];
      end
    end
  end

  assign bus.pix_ready = ready;
  assign bus.shift_en  = beat;
  assign bus.col_idx   = col_q;
  assign bus.row_idx   = row_q;
  assign bus.win_valid = vld_q[LAT-1];
  assign bus.win_col   = tcol_q[LAT-1];
  assign bus.win_row   = trow_q[LAT-1];
  assign bus.busy      = is_busy;
  assign bus.done      = is_done;
endmodule

// File: tb/tb_wavefront_sched.sv
// Directed bench for wavefront_sched: a default 32x32/K5 instance and a small 8x6/K3 instance,
// checked cycle by cycle against a bench-side frame model with a window scoreboard.
module tb_wavefront_sched;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  wavefront_if #(.IMG_W(32), .IMG_H(32)) b0 ();
  wavefront_if #(.IMG_W(8),  .IMG_H(6))  b1 ();

  wavefront_sched #(.IMG_W(32), .IMG_H(32), .KERNEL(5), .WAVEFRONT_DELAY(4)) u_big (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  wavefront_sched #(.IMG_W(8), .IMG_H(6), .KERNEL(3), .WAVEFRONT_DELAY(2)) u_small (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  // Runs one frame on instance sel (0 = default, 1 = small) with a bench model of the
  // sequencer; window tags are encoded as row*256+col.
  task automatic run_frame(input int sel, input bit stall, input bit spam, input bit abort,
                           output int beats, output int wins, output int dones,
                           output int first_lag, output int first_tag, output int last_tag,
                           output int done_lag);
    int W, H, K, L;
    int m_st, m_row, m_col, dcnt, nb, last_beat, first_src;
    bit started, finished, exp_w, pv, st, rn;
    int q_due[$], q_tag[$];
    logic [31:0] o_rdy, o_busy, o_done, o_col, o_row, o_win, o_tag, o_sh;
    W = sel ? 8 : 32;  H = sel ? 6 : 32;  K = sel ? 3 : 5;  L = sel ? 4 : 16;
    m_st = 0; m_row = 0; m_col = 0; dcnt = 0; nb = 0; last_beat = 0; first_src = 0;
    started = 0; finished = 0;
    wins = 0; dones = 0; first_lag = -1; first_tag = -1; last_tag = -1; done_lag = -1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      o_rdy  = sel ? 32'(b1.pix_ready) : 32'(b0.pix_ready);
      o_busy = sel ? 32'(b1.busy)      : 32'(b0.busy);
      o_done = sel ? 32'(b1.done)      : 32'(b0.done);
      o_col  = sel ? 32'(b1.col_idx)   : 32'(b0.col_idx);
      o_row  = sel ? 32'(b1.row_idx)   : 32'(b0.row_idx);
      o_win  = sel ? 32'(b1.win_valid) : 32'(b0.win_valid);
      o_tag  = sel ? 32'(b1.win_row) * 256 + 32'(b1.win_col)
                   : 32'(b0.win_row) * 256 + 32'(b0.win_col);
      n_checks += 6;
      if (o_rdy !== 32'(m_st == 1)) begin n_errors++; $display("FAIL pix_ready @%0d: got %0d want %0d", i, o_rdy, m_st == 1); end
      if (o_busy !== 32'(m_st == 1 || m_st == 2)) begin n_errors++; $display("FAIL busy @%0d: got %0d want %0d", i, o_busy, m_st == 1 || m_st == 2); end
      if (o_done !== 32'(m_st == 3)) begin n_errors++; $display("FAIL done @%0d: got %0d want %0d", i, o_done, m_st == 3); end
      if (o_col !== 32'(m_col)) begin n_errors++; $display("FAIL col_idx @%0d: got %0d want %0d", i, o_col, m_col); end
      if (o_row !== 32'(m_row)) begin n_errors++; $display("FAIL row_idx @%0d: got %0d want %0d", i, o_row, m_row); end
      exp_w = (q_due.size() > 0) && (q_due[0] == i);
      if (o_win !== 32'(exp_w)) begin n_errors++; $display("FAIL win_valid @%0d: got %0d want %0d", i, o_win, exp_w); end
      if (exp_w) begin
        n_checks++;
        if (o_tag !== 32'(q_tag[0])) begin n_errors++; $display("FAIL win_tag @%0d: got %0h want %0h", i, o_tag, q_tag[0]); end
        void'(q_due.pop_front());
        void'(q_tag.pop_front());
      end
      if (o_win === 32'd1) begin
        if (wins == 0) begin first_lag = i - first_src; first_tag = int'(o_tag); end
        last_tag = int'(o_tag);
        wins++;
      end
      if (o_done === 32'd1) begin dones++; done_lag = i - last_beat; end
      if (started && m_st == 0) begin finished = 1; break; end
      // Drive the next edge.
      st = (m_st == 0 && !started) ||
           (spam && m_st != 0 && (m_st == 3 || (m_st == 2 && dcnt == 3) || (i % 37) == 5));
      pv = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      rn = abort && m_st == 1 && m_row == 10 && m_col == 5;
      rst = rn;
      b0.start = sel ? 1'b0 : st;  b0.pix_valid = sel ? 1'b0 : pv;
      b1.start = sel ? st : 1'b0;  b1.pix_valid = sel ? pv : 1'b0;
      #1;
      o_sh = sel ? 32'(b1.shift_en) : 32'(b0.shift_en);
      n_checks++;
      if (o_sh !== 32'(pv && m_st == 1)) begin n_errors++; $display("FAIL shift_en @%0d: got %0d want %0d", i, o_sh, pv && m_st == 1); end
      if (rn) begin
        m_st = 0; m_row = 0; m_col = 0; dcnt = 0;
        q_due.delete(); q_tag.delete();
      end else begin
        case (m_st)
          0: if (st) begin m_st = 1; m_row = 0; m_col = 0; nb = 0; started = 1; end
          1: if (pv) begin
            if (m_row >= K - 1 && m_col >= K - 1) begin
              q_due.push_back(i + L);
              q_tag.push_back((m_row - K + 1) * 256 + (m_col - K + 1));
            end
            if (nb == (K - 1) * W + (K - 1)) first_src = i;
            nb++;
            if (m_col == W - 1) begin m_col = 0; m_row = (m_row == H - 1) ? 0 : m_row + 1; end
            else m_col++;
            if (nb == W * H) begin m_st = 2; dcnt = 0; last_beat = i; end
          end
          2: begin dcnt++; if (dcnt == L) m_st = 3; end
          default: m_st = 0;
        endcase
      end
    end
    n_checks++;
    if (!finished) begin n_errors++; $display("FAIL frame_timeout: got %0d want %0d", finished, 1); end
    rst = 1'b0;
    b0.start = 1'b0; b0.pix_valid = 1'b0;
    b1.start = 1'b0; b1.pix_valid = 1'b0;
    beats = nb;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b0.start = 1'b1; b0.pix_valid = 1'b1;
    b1.start = 1'b1; b1.pix_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks += 2;
      if ({b0.pix_ready, b0.shift_en, b0.busy, b0.done, b0.win_valid} !== 5'b0) begin n_errors++; $display("FAIL reset_flags: got %b want 00000", {b0.pix_ready, b0.shift_en, b0.busy, b0.done, b0.win_valid}); end
      if ({b0.col_idx, b0.row_idx, b0.win_col, b0.win_row, b1.busy} !== 21'b0) begin n_errors++; $display("FAIL reset_values: got %0h want 0", {b0.col_idx, b0.row_idx, b0.win_col, b0.win_row, b1.busy}); end
    end
    rst = 1'b0; b0.start = 1'b0; b1.start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({b0.pix_ready, b0.shift_en, b0.busy, b0.col_idx, b0.row_idx} !== 13'b0) begin n_errors++; $display("FAIL idle_no_beat: got %0h want 0", {b0.pix_ready, b0.shift_en, b0.busy, b0.col_idx, b0.row_idx}); end
    end
    b0.pix_valid = 1'b0; b1.pix_valid = 1'b0;
  endtask

  task automatic test_continuous();
    int nb, nw, nd, fl, ft, lt, dl;
    run_frame(0, 0, 0, 0, nb, nw, nd, fl, ft, lt, dl);
    n_checks += 7;
    if (nb != 1024) begin n_errors++; $display("FAIL cont_beats: got %0d want 1024", nb); end
    if (nw != 784) begin n_errors++; $display("FAIL cont_windows: got %0d want 784", nw); end
    if (nd != 1) begin n_errors++; $display("FAIL cont_dones: got %0d want 1", nd); end
    if (fl != 16) begin n_errors++; $display("FAIL cont_first_lag: got %0d want 16", fl); end
    if (ft != 0) begin n_errors++; $display("FAIL cont_first_tag: got %0h want 0", ft); end
    if (lt != 27 * 256 + 27) begin n_errors++; $display("FAIL cont_last_tag: got %0h want %0h", lt, 27 * 256 + 27); end
    if (dl != 17) begin n_errors++; $display("FAIL cont_done_lag: got %0d want 17", dl); end
  endtask

  task automatic test_stalls();
    int nb, nw, nd, fl, ft, lt, dl;
    run_frame(0, 1, 0, 0, nb, nw, nd, fl, ft, lt, dl);
    n_checks += 4;
    if (nb != 1024) begin n_errors++; $display("FAIL stall_beats: got %0d want 1024", nb); end
    if (nw != 784) begin n_errors++; $display("FAIL stall_windows: got %0d want 784", nw); end
    if (nd != 1) begin n_errors++; $display("FAIL stall_dones: got %0d want 1", nd); end
    if (fl != 16) begin n_errors++; $display("FAIL stall_first_lag: got %0d want 16", fl); end
  endtask

  task automatic test_start_ignored();
    int nb, nw, nd, fl, ft, lt, dl;
    run_frame(0, 0, 1, 0, nb, nw, nd, fl, ft, lt, dl);
    n_checks += 3;
    if (nb != 1024) begin n_errors++; $display("FAIL spam_beats: got %0d want 1024", nb); end
    if (nw != 784) begin n_errors++; $display("FAIL spam_windows: got %0d want 784", nw); end
    if (nd != 1) begin n_errors++; $display("FAIL spam_dones: got %0d want 1", nd); end
  endtask

  task automatic test_reset_mid();
    int nb, nw, nd, fl, ft, lt, dl;
    run_frame(0, 0, 0, 1, nb, nw, nd, fl, ft, lt, dl);
    n_checks++;
    if (nd != 0) begin n_errors++; $display("FAIL abort_dones: got %0d want 0", nd); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++;
      if ({b0.win_valid, b0.busy, b0.done} !== 3'b0) begin n_errors++; $display("FAIL abort_quiet @%0d: got %b want 000", c, {b0.win_valid, b0.busy, b0.done}); end
    end
    run_frame(0, 0, 0, 0, nb, nw, nd, fl, ft, lt, dl);
    n_checks += 3;
    if (nw != 784) begin n_errors++; $display("FAIL restart_windows: got %0d want 784", nw); end
    if (ft != 0) begin n_errors++; $display("FAIL restart_first_tag: got %0h want 0", ft); end
    if (nd != 1) begin n_errors++; $display("FAIL restart_dones: got %0d want 1", nd); end
  endtask

  task automatic test_small();
    int nb, nw, nd, fl, ft, lt, dl;
    run_frame(1, 0, 0, 0, nb, nw, nd, fl, ft, lt, dl);
    n_checks += 6;
    if (nb != 48) begin n_errors++; $display("FAIL small_beats: got %0d want 48", nb); end
    if (nw != 24) begin n_errors++; $display("FAIL small_windows: got %0d want 24", nw); end
    if (fl != 4) begin n_errors++; $display("FAIL small_first_lag: got %0d want 4", fl); end
    if (dl != 5) begin n_errors++; $display("FAIL small_done_lag: got %0d want 5", dl); end
    if (nd != 1) begin n_errors++; $display("FAIL small_dones: got %0d want 1", nd); end
    if (lt != 3 * 256 + 5) begin n_errors++; $display("FAIL small_last_tag: got %0h want %0h", lt, 3 * 256 + 5); end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_stalls();
    test_start_ignored();
    test_reset_mid();
    test_small();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
